// File: rtl/score_display_pkg.sv
// Shared constants for the score display: widths, FSM encoding
// and the active-high 7-segment patterns (bit 0 = a .. bit 6 = g).
package score_display_pkg;

   localparam int SCORE_W = 14;
   localparam int DIGITS  = 4;
   localparam logic [SCORE_W-1:0] MAX_SCORE = 14'd9999;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      LATCH
   } state_t;

   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/score_display_seg7_decode.sv
// BCD nibble to active-high segments; blank flag or a non-decimal
// nibble turns every segment off.
module seg7_decode
   import score_display_pkg::*;
(
   input  logic [3:0] i_Bcd,
   input  logic       i_Blank,
   output logic [6:0] o_Seg
);

   always_comb begin
      o_Seg = SEG_BLANK;
      if (!i_Blank) begin
         case (i_Bcd)
            4'd0:    o_Seg = SEG_0;
            4'd1:    o_Seg = SEG_1;
            4'd2:    o_Seg = SEG_2;
            4'd3:    o_Seg = SEG_3;
            4'd4:    o_Seg = SEG_4;
            4'd5:    o_Seg = SEG_5;
            4'd6:    o_Seg = SEG_6;
            4'd7:    o_Seg = SEG_7;
            4'd8:    o_Seg = SEG_8;
            4'd9:    o_Seg = SEG_9;
            default: o_Seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/score_display.sv
// Binary score to BCD via a sequential double-dabble FSM, shown on
// a time-multiplexed 4-digit 7-segment display.
module score_display
   import score_display_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit BLANK_LEADING  = 1'b1
) (
   input  logic        i_Clk,
   input  logic        i_Rst,
   input  logic [13:0] i_Score,
   output logic [15:0] o_Bcd,
   output logic        o_Busy,
   output logic [3:0]  o_Digit,
   output logic [6:0]  o_Seg
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] PRESC_TC = PW'(SCAN_DIV - 1);
   localparam logic [3:0] DIG_OFF = SEG_ACTIVE_LOW ? 4'hF : 4'h0;
   localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

   state_t state_q, state_d;
   logic [SCORE_W-1:0] bin_q, bin_d;
   logic [SCORE_W-1:0] last_q, last_d;
   logic [15:0] acc_q, acc_d;
   logic [15:0] bcd_q, bcd_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [1:0]  idx_q, idx_d;
   logic [3:0]  digit_q, digit_d;
   logic [6:0]  seg_q, seg_d;

   logic [SCORE_W-1:0] score_c;
   logic [15:0] adj;
   logic [15:0] higher;
   logic [3:0]  nib;
   logic        blank;
   logic [3:0]  onehot;
   logic [6:0]  seg_raw;

   assign score_c = (i_Score > MAX_SCORE) ? MAX_SCORE : i_Score;

   always_comb begin
      adj = acc_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      last_d  = last_q;
      acc_d   = acc_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (score_c != last_q) begin
               bin_d   = score_c;
               last_d  = score_c;
               acc_d   = 16'd0;
               cnt_d   = 4'd0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            {acc_d, bin_d} = {adj, bin_q} << 1;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd13) begin
               state_d = LATCH;
            end
         end
         LATCH: begin
            bcd_d   = acc_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Scan always reads the latched result, never the accumulator.
   always_comb begin
      presc_d = presc_q + PW'(1);
      idx_d   = idx_q;
      if (presc_q == PRESC_TC) begin
         presc_d = '0;
         idx_d   = idx_q + 2'd1;
      end
      higher  = bcd_q >> {idx_q, 2'b00};
      nib     = higher[3:0];
      blank   = BLANK_LEADING && (idx_q != 2'd0) && (higher == 16'd0);
      onehot  = 4'b0001 << idx_q;
      digit_d = SEG_ACTIVE_LOW ? ~onehot : onehot;
      seg_d   = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
   end

   seg7_decode u_dec (
      .i_Bcd   (nib),
      .i_Blank (blank),
      .o_Seg   (seg_raw)
   );

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state_q <= IDLE;
         bin_q   <= '0;
         last_q  <= '0;
         acc_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         presc_q <= '0;
         idx_q   <= '0;
         digit_q <= DIG_OFF;
         seg_q   <= SEG_OFF;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         last_q  <= last_d;
         acc_q   <= acc_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         presc_q <= presc_d;
         idx_q   <= idx_d;
         digit_q <= digit_d;
         seg_q   <= seg_d;
      end
   end

   assign o_Bcd   = bcd_q;
   assign o_Busy  = (state_q != IDLE);
   assign o_Digit = digit_q;
   assign o_Seg   = seg_q;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: conversion latency, clamping,
// busy-time input changes, scan order, blanking and async reset.
module tb_score_display;

   logic        i_Clk;
   logic        i_Rst;
   logic [13:0] i_Score;
   logic [15:0] o_Bcd;
   logic        o_Busy;
   logic [3:0]  o_Digit;
   logic [6:0]  o_Seg;

   int n_chk;
   int n_fail;

   score_display #(
      .SCAN_DIV       (4),
      .SEG_ACTIVE_LOW (1'b1),
      .BLANK_LEADING  (1'b1)
   ) dut (
      .i_Clk   (i_Clk),
      .i_Rst   (i_Rst),
      .i_Score (i_Score),
      .o_Bcd   (o_Bcd),
      .o_Busy  (o_Busy),
      .o_Digit (o_Digit),
      .o_Seg   (o_Seg)
   );

   initial i_Clk = 1'b0;
   always #5 i_Clk = ~i_Clk;

   typedef struct {
      logic [13:0]      score;
      logic [15:0]      bcd;
      logic [3:0][6:0]  seg;
   } vec_t;

   vec_t vecs [7];

   task automatic tick();
      @(posedge i_Clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Score must already be applied; the next edge is the detect edge.
   task automatic run_conv(input string name, input logic [15:0] exp);
      int n;
      logic [15:0] held;
      logic moved;
      held  = o_Bcd;
      moved = 1'b0;
      tick();
      check({name, "_busy_start"}, 32'(o_Busy), 32'd1);
      n = 1;
      for (int g = 0; g < 40; g++) begin
         tick();
         if (!o_Busy) break;
         n++;
         if (o_Bcd !== held) moved = 1'b1;
      end
      check({name, "_bcd_held"}, 32'(moved), 32'd0);
      check({name, "_busy_len"}, n, 15);
      check({name, "_bcd"}, 32'(o_Bcd), 32'(exp));
   endtask

   task automatic check_scan(input string name, input logic [3:0][6:0] exp);
      logic [3:0] prev;
      logic [3:0] dig;
      bit found;
      found = 1'b0;
      for (int g = 0; g < 40; g++) begin
         prev = o_Digit;
         tick();
         if (o_Digit == 4'b1110 && prev != 4'b1110) begin
            found = 1'b1;
            break;
         end
      end
      check({name, "_sync"}, 32'(found), 32'd1);
      for (int k = 0; k < 5; k++) begin
         for (int c = 0; c < 4; c++) begin
            if (k != 0 || c != 0) tick();
            dig = ~(4'b0001 << (k % 4));
            check($sformatf("%s_dig%0d_c%0d", name, k, c),
                  32'(o_Digit), 32'(dig));
            check($sformatf("%s_seg%0d_c%0d", name, k, c),
                  32'(o_Seg), 32'(exp[k % 4]));
         end
      end
   endtask

   initial begin
      int quiet;
      int n;
      bit bad;
      n_chk  = 0;
      n_fail = 0;

      vecs[0] = '{14'd9999, 16'h9999,
                 {7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000}};
      vecs[1] = '{14'd1234, 16'h1234,
                 {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
      vecs[2] = '{14'd105, 16'h0105,
                 {7'b1111111, 7'b1111001, 7'b1000000, 7'b0010010}};
      vecs[3] = '{14'd7, 16'h0007,
                 {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000}};
      vecs[4] = '{14'd8000, 16'h8000,
                 {7'b0000000, 7'b1000000, 7'b1000000, 7'b1000000}};
      vecs[5] = '{14'd4096, 16'h4096,
                 {7'b0011001, 7'b1000000, 7'b0010000, 7'b0000010}};
      vecs[6] = '{14'd12000, 16'h9999,
                 {7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000}};

      i_Rst   = 1'b1;
      i_Score = 14'd0;
      #23;
      check("rst_digit", 32'(o_Digit), 32'hF);
      check("rst_seg", 32'(o_Seg), 32'h7F);
      check("rst_busy", 32'(o_Busy), 32'd0);
      i_Rst = 1'b0;

      quiet = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (o_Busy) quiet++;
      end
      check("idle0_busy", quiet, 0);
      check("idle0_bcd", 32'(o_Bcd), 32'h0);
      check_scan("scan0",
                 {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000});

      for (int v = 0; v < 7; v++) begin
         i_Score = vecs[v].score;
         run_conv($sformatf("vec%0d", v), vecs[v].bcd);
         check_scan($sformatf("vec%0d_scan", v), vecs[v].seg);
      end

      // Clamped 13000 equals the stored 9999, so nothing starts.
      i_Score = 14'd13000;
      quiet = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (o_Busy) quiet++;
      end
      check("clamp_no_conv", quiet, 0);
      check("clamp_bcd", 32'(o_Bcd), 32'h9999);

      // Change the score on the 3rd busy cycle; both values convert.
      i_Score = 14'd5;
      bad = 1'b0;
      tick();
      check("b2b_busy1", 32'(o_Busy), 32'd1);
      tick();
      tick();
      i_Score = 14'd10;
      n = 3;
      for (int g = 0; g < 40; g++) begin
         tick();
         if (o_Bcd !== 16'h9999) bad = 1'b1;
         if (!o_Busy) break;
         n++;
      end
      check("b2b_len1", n, 15);
      check("b2b_bcd1", 32'(o_Bcd), 32'h0005);
      bad = 1'b0;
      tick();
      check("b2b_restart", 32'(o_Busy), 32'd1);
      n = 1;
      for (int g = 0; g < 40; g++) begin
         tick();
         if (o_Bcd !== 16'h0005 && o_Bcd !== 16'h0010) bad = 1'b1;
         if (!o_Busy) break;
         n++;
      end
      check("b2b_len2", n, 15);
      check("b2b_bcd2", 32'(o_Bcd), 32'h0010);
      check("b2b_no_partial", 32'(bad), 32'd0);

      // Async reset on the 7th SHIFT cycle of a 9999 conversion.
      i_Score = 14'd9999;
      tick();
      check("rstmid_busy", 32'(o_Busy), 32'd1);
      for (int c = 0; c < 6; c++) tick();
      check("rstmid_still", 32'(o_Busy), 32'd1);
      i_Rst = 1'b1;
      #1;
      check("rstmid_busy0", 32'(o_Busy), 32'd0);
      check("rstmid_bcd0", 32'(o_Bcd), 32'h0);
      check("rstmid_digit", 32'(o_Digit), 32'hF);
      check("rstmid_seg", 32'(o_Seg), 32'h7F);
      tick();
      tick();
      check("rstmid_hold_bcd", 32'(o_Bcd), 32'h0);
      i_Rst = 1'b0;
      run_conv("rst_reconv", 16'h9999);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
